// File: rtl/axis_gearbox.sv
// rtl/axis_gearbox.sv - AXI4-Stream byte-lane gearbox for arbitrary (non-integer) lane ratios.
// Define AXIS_GEARBOX_KEEP_CHECK_EN to enable the sticky illegal-tkeep flag.
module axis_gearbox #(
  parameter int S_DATA_WIDTH  = 24,
  parameter bit S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = ((S_DATA_WIDTH + 7) / 8),
  parameter int M_DATA_WIDTH  = 32,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = ((M_DATA_WIDTH + 7) / 8),
  parameter bit ID_ENABLE     = 0,
  parameter int ID_WIDTH      = 1,
  parameter bit DEST_ENABLE   = 0,
  parameter int DEST_WIDTH    = 1,
  parameter bit USER_ENABLE   = 1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    keep_err
);
  localparam int S         = S_KEEP_ENABLE ? S_KEEP_WIDTH : 1;
  localparam int M         = M_KEEP_ENABLE ? M_KEEP_WIDTH : 1;
  localparam int BUF_LANES = 2 * (S + M);
  localparam int BW        = S_DATA_WIDTH / S;
  localparam int CW        = $clog2(BUF_LANES + 1);

  if ((S * BW != S_DATA_WIDTH) || (M * BW != M_DATA_WIDTH)) begin : g_bad_width
    $error("axis_gearbox: input and output byte sizes differ");
  end

  logic [BW-1:0]         lane_q [BUF_LANES];
  logic [BW-1:0]         lane_d [BUF_LANES];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  last_pending_q;
  logic                  mid_pkt_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [S-1:0]          keep_in;
  logic [M-1:0]          keep_o;
  logic                  s_fire;
  logic                  m_fire;
  int                    cnt;
  int                    out_n;
  int                    pop_n;
  int                    push_n;
  int                    base;

  if (S_KEEP_ENABLE) begin : g_skeep
    assign keep_in = s_axis_tkeep[S-1:0];
  end else begin : g_sfull
    assign keep_in = '1;
  end

  logic unused_ok;
  assign unused_ok = ^{1'b0, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser};

  // Handshake flags depend on registers only, so there is no ready->ready path.
  assign s_axis_tready = !last_pending_q && (count_q <= CW'(BUF_LANES - S));
  assign m_axis_tvalid = (count_q >= CW'(M)) || last_pending_q;
  assign m_axis_tlast  = last_pending_q && (count_q <= CW'(M));
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = m_axis_tvalid && m_axis_tready;

  always_comb begin
    cnt    = int'(count_q);
    out_n  = (cnt < M) ? cnt : M;
    pop_n  = m_fire ? out_n : 0;
    push_n = 0;
    for (int i = 0; i < S; i++) begin
      if (keep_in[i]) push_n++;
    end
    if (!s_fire) push_n = 0;
    base = cnt - pop_n;
    // Shift out the emitted bytes, then append the new beat packed from lane 0.
    for (int j = 0; j < BUF_LANES; j++) begin
      lane_d[j] = '0;
      if (j + pop_n < BUF_LANES) lane_d[j] = lane_q[j + pop_n];
    end
    for (int k = 0; k < S; k++) begin
      if (k < push_n) lane_d[base + k] = s_axis_tdata[k*BW +: BW];
    end
    count_d = CW'(base + push_n);
  end

  always_comb begin
    m_axis_tdata = '0;
    keep_o       = '0;
    for (int j = 0; j < M; j++) begin
      if (j < out_n) begin
        m_axis_tdata[j*BW +: BW] = lane_q[j];
        keep_o[j]                = 1'b1;
      end
    end
  end

  if (M_KEEP_ENABLE) begin : g_mkeep
    assign m_axis_tkeep = keep_o;
  end else begin : g_mfull
    assign m_axis_tkeep = '1;
  end

  assign m_axis_tid   = ID_ENABLE ? id_q : '0;
  assign m_axis_tdest = DEST_ENABLE ? dest_q : '0;
  assign m_axis_tuser = (USER_ENABLE && m_axis_tlast) ? user_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q         <= '{default: '0};
      count_q        <= '0;
      last_pending_q <= 1'b0;
      mid_pkt_q      <= 1'b0;
      id_q           <= '0;
      dest_q         <= '0;
      user_q         <= '0;
    end else begin
      lane_q  <= lane_d;
      count_q <= count_d;
      if (m_fire && m_axis_tlast) last_pending_q <= 1'b0;
      if (s_fire) begin
        if (!mid_pkt_q) begin
          id_q   <= s_axis_tid;
          dest_q <= s_axis_tdest;
        end
        mid_pkt_q <= !s_axis_tlast;
        if (s_axis_tlast) begin
          last_pending_q <= 1'b1;
          user_q         <= s_axis_tuser;
        end
      end
    end
  end

`ifdef AXIS_GEARBOX_KEEP_CHECK_EN
  logic keep_bad;
  logic keep_err_q;

  // A hole in tkeep, or a short beat that is not the last, is flagged but still packed by popcount.
  always_comb begin
    keep_bad = 1'b0;
    for (int i = 1; i < S; i++) begin
      if (keep_in[i] && !keep_in[i-1]) keep_bad = 1'b1;
    end
    if (!s_axis_tlast && !(&keep_in)) keep_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) keep_err_q <= 1'b0;
    else if (s_fire && keep_bad) keep_err_q <= 1'b1;
  end

  assign keep_err = keep_err_q;
`else
  assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_gearbox.sv
// tb/tb_axis_gearbox.sv - scoreboard bench for axis_gearbox with 3->4, 5->2 and 8->3 lane instances.
module tb_axis_gearbox;
  typedef struct {
    logic [31:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

`ifdef AXIS_GEARBOX_KEEP_CHECK_EN
  localparam logic KERR_EXP = 1'b1;
`else
  localparam logic KERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];

  // Instance A: 3 -> 4 lanes
  logic [23:0] a_sdata = '0;
  logic [2:0]  a_skeep = '0;
  logic        a_svalid = 1'b0, a_slast = 1'b0, a_suser = 1'b0, a_sready;
  logic [31:0] a_mdata;
  logic [3:0]  a_mkeep;
  logic        a_mvalid, a_mlast, a_muser, a_kerr, a_mid, a_mdest;
  logic        a_mready = 1'b1;

  // Instance B: 5 -> 2 lanes
  logic [39:0] b_sdata = '0;
  logic [4:0]  b_skeep = '0;
  logic        b_svalid = 1'b0, b_slast = 1'b0, b_suser = 1'b0, b_sready;
  logic [15:0] b_mdata;
  logic [1:0]  b_mkeep;
  logic        b_mvalid, b_mlast, b_muser, b_kerr, b_mid, b_mdest;
  logic        b_mready = 1'b1;

  // Instance C: 8 -> 3 lanes
  logic [63:0] c_sdata = '0;
  logic [7:0]  c_skeep = '0;
  logic        c_svalid = 1'b0, c_slast = 1'b0, c_suser = 1'b0, c_sready;
  logic [23:0] c_mdata;
  logic [2:0]  c_mkeep;
  logic        c_mvalid, c_mlast, c_muser, c_kerr, c_mid, c_mdest;
  logic        c_mready = 1'b1;

  bit a_rand = 1'b0;
  bit c_rand = 1'b0;

  axis_gearbox #(.S_DATA_WIDTH(24), .M_DATA_WIDTH(32)) u_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_sdata), .s_axis_tkeep(a_skeep), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
    .s_axis_tlast(a_slast), .s_axis_tid(1'b0), .s_axis_tdest(1'b0), .s_axis_tuser(a_suser),
    .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .m_axis_tlast(a_mlast), .m_axis_tid(a_mid), .m_axis_tdest(a_mdest), .m_axis_tuser(a_muser),
    .keep_err(a_kerr)
  );

  axis_gearbox #(.S_DATA_WIDTH(40), .M_DATA_WIDTH(16)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_sdata), .s_axis_tkeep(b_skeep), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
    .s_axis_tlast(b_slast), .s_axis_tid(1'b0), .s_axis_tdest(1'b0), .s_axis_tuser(b_suser),
    .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tlast(b_mlast), .m_axis_tid(b_mid), .m_axis_tdest(b_mdest), .m_axis_tuser(b_muser),
    .keep_err(b_kerr)
  );

  axis_gearbox #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(24)) u_c (
    .clk(clk), .rst(rst),
    .s_axis_tdata(c_sdata), .s_axis_tkeep(c_skeep), .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready),
    .s_axis_tlast(c_slast), .s_axis_tid(1'b0), .s_axis_tdest(1'b0), .s_axis_tuser(c_suser),
    .m_axis_tdata(c_mdata), .m_axis_tkeep(c_mkeep), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
    .m_axis_tlast(c_mlast), .m_axis_tid(c_mid), .m_axis_tdest(c_mdest), .m_axis_tuser(c_muser),
    .keep_err(c_kerr)
  );

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void cmp_beat(string nm, beat_t a, beat_t e);
    n_cmp++;
    if (a.data !== e.data || a.keep !== e.keep || a.last !== e.last || a.user !== e.user) begin
      n_err++;
      $display("FAIL %s: got data=%h keep=%h last=%b user=%b, expected data=%h keep=%h last=%b user=%b",
               nm, a.data, a.keep, a.last, a.user, e.data, e.keep, e.last, e.user);
    end
  endfunction

  function automatic void extra_beat(string nm, logic [31:0] d);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected beat data=%h, expected no beat", nm, d);
  endfunction

  // Chops a packet's byte stream into expected M-lane beats
  function automatic void exp_pkt(int inst, int m, logic [7:0] bytes[$], logic u);
    int n = bytes.size();
    int pos = 0;
    do begin
      beat_t e;
      int k = (n - pos < m) ? n - pos : m;
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < k; i++) begin
        e.data[i*8 +: 8] = bytes[pos + i];
        e.keep[i] = 1'b1;
      end
      pos += k;
      e.last = (pos == n);
      e.user = e.last ? u : 1'b0;
      case (inst)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end while (pos < n);
  endfunction

  // Monitors: pop and compare on every output handshake; check AXI stability while stalled
  beat_t a_cur, a_hold, b_cur, c_cur, c_hold;
  bit a_stall = 1'b0;
  bit c_stall = 1'b0;

  always @(negedge clk) begin
    a_cur = '{a_mdata, 8'(a_mkeep), a_mlast, a_muser};
    if (a_stall && !rst) begin
      check("A_stall_valid", a_mvalid, 1);
      cmp_beat("A_stall_stable", a_cur, a_hold);
    end
    if (!rst && a_mvalid && a_mready) begin
      if (qa.size() == 0) extra_beat("A_beat", a_mdata);
      else cmp_beat("A_beat", a_cur, qa.pop_front());
    end
    a_stall = !rst && a_mvalid && !a_mready;
    a_hold  = a_cur;
  end

  always @(negedge clk) begin
    b_cur = '{32'(b_mdata), 8'(b_mkeep), b_mlast, b_muser};
    if (!rst && b_mvalid && b_mready) begin
      if (qb.size() == 0) extra_beat("B_beat", 32'(b_mdata));
      else cmp_beat("B_beat", b_cur, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    c_cur = '{32'(c_mdata), 8'(c_mkeep), c_mlast, c_muser};
    if (c_stall && !rst) begin
      check("C_stall_valid", c_mvalid, 1);
      cmp_beat("C_stall_stable", c_cur, c_hold);
    end
    if (!rst && c_mvalid && c_mready) begin
      if (qc.size() == 0) extra_beat("C_beat", 32'(c_mdata));
      else cmp_beat("C_beat", c_cur, qc.pop_front());
    end
    c_stall = !rst && c_mvalid && !c_mready;
    c_hold  = c_cur;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (a_rand) a_mready = 1'($urandom_range(0, 1));
    if (c_rand) c_mready = 1'($urandom_range(0, 1));
  end

  // Drivers: called at posedge+1, return at posedge+1 after the beat is taken
  task automatic send_a(input logic [23:0] d, input logic [2:0] k, input logic l, input logic u);
    int t = 0;
    a_sdata = d; a_skeep = k; a_slast = l; a_suser = u; a_svalid = 1'b1;
    @(negedge clk);
    while (!a_sready && t < 1000) begin t++; @(negedge clk); end
    if (!a_sready) begin n_cmp++; n_err++; $display("FAIL A_send_timeout: tready stayed 0, expected 1"); end
    @(posedge clk); #1;
    a_svalid = 1'b0;
  endtask

  task automatic send_b(input logic [39:0] d, input logic [4:0] k, input logic l, input logic u);
    int t = 0;
    b_sdata = d; b_skeep = k; b_slast = l; b_suser = u; b_svalid = 1'b1;
    @(negedge clk);
    while (!b_sready && t < 1000) begin t++; @(negedge clk); end
    if (!b_sready) begin n_cmp++; n_err++; $display("FAIL B_send_timeout: tready stayed 0, expected 1"); end
    @(posedge clk); #1;
    b_svalid = 1'b0;
  endtask

  task automatic send_c(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int t = 0;
    c_sdata = d; c_skeep = k; c_slast = l; c_suser = u; c_svalid = 1'b1;
    @(negedge clk);
    while (!c_sready && t < 1000) begin t++; @(negedge clk); end
    if (!c_sready) begin n_cmp++; n_err++; $display("FAIL C_send_timeout: tready stayed 0, expected 1"); end
    @(posedge clk); #1;
    c_svalid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 2000) begin t++; @(posedge clk); end
    #1;
    check(nm, qa.size() + qb.size() + qc.size(), 0);
  endtask

  task automatic rand_a(input int npkt);
    for (int p = 0; p < npkt; p++) begin
      int nb = $urandom_range(1, 4);
      int lastn = $urandom_range(1, 3);
      logic u = 1'($urandom_range(0, 1));
      logic [7:0] bytes[$];
      logic [23:0] d;
      for (int i = 0; i < (nb - 1) * 3 + lastn; i++) bytes.push_back(8'($urandom));
      exp_pkt(0, 4, bytes, u);
      for (int b = 0; b < nb; b++) begin
        int n = (b == nb - 1) ? lastn : 3;
        d = 24'($urandom);
        for (int i = 0; i < n; i++) d[i*8 +: 8] = bytes[b*3 + i];
        send_a(d, 3'((1 << n) - 1), b == nb - 1, (b == nb - 1) ? u : 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic rand_c(input int npkt);
    for (int p = 0; p < npkt; p++) begin
      int nb = $urandom_range(1, 4);
      int lastn = $urandom_range(1, 8);
      logic u = 1'($urandom_range(0, 1));
      logic [7:0] bytes[$];
      logic [63:0] d;
      for (int i = 0; i < (nb - 1) * 8 + lastn; i++) bytes.push_back(8'($urandom));
      exp_pkt(2, 3, bytes, u);
      for (int b = 0; b < nb; b++) begin
        int n = (b == nb - 1) ? lastn : 8;
        d = {$urandom, $urandom};
        for (int i = 0; i < n; i++) d[i*8 +: 8] = bytes[b*8 + i];
        send_c(d, 8'((1 << n) - 1), b == nb - 1, (b == nb - 1) ? u : 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("A_reset_tvalid", a_mvalid, 0);
    check("A_reset_tlast", a_mlast, 0);
    check("A_reset_tdata", a_mdata, 0);
    check("A_reset_tkeep", a_mkeep, 0);
    check("A_reset_tuser", a_muser, 0);
    check("A_reset_keep_err", a_kerr, 0);
    check("A_reset_tready", a_sready, 1);
    check("B_reset_tready", b_sready, 1);
    check("C_reset_tvalid", c_mvalid, 0);

    // 3->4: 12-byte packet, three full beats
    qa.push_back('{32'h03020100, 8'hF, 1'b0, 1'b0});
    qa.push_back('{32'h07060504, 8'hF, 1'b0, 1'b0});
    qa.push_back('{32'h0B0A0908, 8'hF, 1'b1, 1'b1});
    send_a(24'h020100, 3'b111, 1'b0, 1'b0);
    send_a(24'h050403, 3'b111, 1'b0, 1'b0);
    send_a(24'h080706, 3'b111, 1'b0, 1'b0);
    send_a(24'h0B0A09, 3'b111, 1'b1, 1'b1);
    // 3->4: 6-byte packet, partial flush on tlast
    qa.push_back('{32'h03020100, 8'hF, 1'b0, 1'b0});
    qa.push_back('{32'h00000504, 8'h3, 1'b1, 1'b0});
    send_a(24'h020100, 3'b111, 1'b0, 1'b1);
    send_a(24'h050403, 3'b111, 1'b1, 1'b0);
    // zero-byte packet, then a single-byte packet
    qa.push_back('{32'h00000000, 8'h0, 1'b1, 1'b1});
    send_a(24'hABCDEF, 3'b000, 1'b1, 1'b1);
    qa.push_back('{32'h0000005A, 8'h1, 1'b1, 1'b0});
    send_a(24'hC3B25A, 3'b001, 1'b1, 1'b0);
    drain("A_directed_drain");

    // 5->2: one full tlast beat, tready held low until the last beat pops
    qb.push_back('{32'h0100, 8'h3, 1'b0, 1'b0});
    qb.push_back('{32'h0302, 8'h3, 1'b0, 1'b0});
    qb.push_back('{32'h0004, 8'h1, 1'b1, 1'b1});
    send_b(40'h0403020100, 5'h1F, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("B_tready_while_draining", b_sready, 0);
    end
    @(negedge clk);
    check("B_tready_after_last", b_sready, 1);
    @(posedge clk); #1;
    qb.push_back('{32'h1110, 8'h3, 1'b0, 1'b0});
    qb.push_back('{32'h1312, 8'h3, 1'b0, 1'b0});
    qb.push_back('{32'h1514, 8'h3, 1'b0, 1'b0});
    qb.push_back('{32'h0016, 8'h1, 1'b1, 1'b0});
    send_b(40'h1413121110, 5'h1F, 1'b0, 1'b1);
    send_b(40'hFFFFFF1615, 5'h03, 1'b1, 1'b0);
    drain("B_directed_drain");

    // Reset mid-packet with 5 bytes buffered
    a_mready = 1'b0;
    send_a(24'h222120, 3'b111, 1'b0, 1'b0);
    send_a(24'h252423, 3'b111, 1'b0, 1'b0);
    send_a(24'h282726, 3'b111, 1'b0, 1'b0);
    qa.push_back('{32'h23222120, 8'hF, 1'b0, 1'b0});
    a_mready = 1'b1;
    @(posedge clk); #1;
    a_mready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("A_rst_mid_tvalid", a_mvalid, 0);
    check("A_rst_mid_tready", a_sready, 1);
    check("A_rst_mid_tdata", a_mdata, 0);
    a_mready = 1'b1;
    qa.push_back('{32'h33323130, 8'hF, 1'b0, 1'b0});
    qa.push_back('{32'h00003534, 8'h3, 1'b1, 1'b1});
    send_a(24'h323130, 3'b111, 1'b0, 1'b0);
    send_a(24'h353433, 3'b111, 1'b1, 1'b1);
    drain("A_after_reset_drain");

    // Random traffic with 50% output backpressure on 3->4 and 8->3
    a_rand = 1'b1;
    c_rand = 1'b1;
    fork
      rand_a(1000);
      rand_c(1000);
    join
    a_rand = 1'b0;
    c_rand = 1'b0;
    a_mready = 1'b1;
    c_mready = 1'b1;
    drain("random_drain");

    // Non-contiguous tkeep on a non-last beat: packed by popcount, flagged when checking is built in
    check("A_keep_err_before", a_kerr, 0);
    qa.push_back('{32'h04030100, 8'hF, 1'b0, 1'b0});
    qa.push_back('{32'h00000005, 8'h1, 1'b1, 1'b0});
    send_a(24'h020100, 3'b101, 1'b0, 1'b0);
    send_a(24'h050403, 3'b111, 1'b1, 1'b0);
    check("A_keep_err_set", a_kerr, KERR_EXP);
    repeat (5) @(posedge clk);
    #1;
    check("A_keep_err_sticky", a_kerr, KERR_EXP);
    check("B_keep_err_clear", b_kerr, 0);
    check("C_keep_err_clear", c_kerr, 0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
